// File: rtl/tamagotchi_pkg.sv
// tamagotchi_pkg
// Shared definitions for the tamagotchi button front end and the FSM it feeds:
//   - hold-FSM state type and its three state constants (IDLE/HOLDING/FIRED)
//   - width of the hold-second counters (saturating at COUNT_MAX)
//   - care-button priority indices; a lower index wins a same-cycle tie
// No ports; this is a package.
package tamagotchi_pkg;

  localparam int COUNT_W = 3;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 3'd7;

  typedef logic [1:0] hold_state_t;
  localparam hold_state_t HOLD_IDLE    = 2'd0;
  localparam hold_state_t HOLD_HOLDING = 2'd1;
  localparam hold_state_t HOLD_FIRED   = 2'd2;

  localparam int NUM_CARE       = 4;
  localparam int CARE_SALUD     = 0;
  localparam int CARE_ENERGIA   = 1;
  localparam int CARE_HAMBRE    = 2;
  localparam int CARE_DIVERSION = 3;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchroniser followed by a counting debouncer for one pushbutton.
// The debounced level only moves after the synchronised sample has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; one agreeing sample restarts
// the count.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   unsynchronised button, active-high
//   level  out  debounced level
//   rise   out  one-cycle strobe, high in the cycle after level goes 0->1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter holds how many disagreeing samples have been seen so far; the
  // sample that would make it DEBOUNCE_CYCLES flips the level instead.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/tamagotchi_btn_frontend.sv
// tamagotchi_btn_frontend
// Button conditioner in front of tamagotchi_fsm. Six raw buttons are
// synchronised and debounced; the four care buttons become one-cycle command
// pulses (priority salud > energia > hambre > diversion, suppressed while the
// reset or test button is held down), and the reset/test buttons run a
// hold timer that pulses once after HOLD_SECS "seconds" of TICK_CYCLES each.
// Optional feature macro: BTN_AUTOREPEAT_EN -- when defined, a care button
// held for one TICK_CYCLES period re-emits its pulse every REPEAT_CYCLES.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   raw_salud .. raw_test              raw active-high pushbuttons
//   btn_salud .. btn_diversion         one-cycle care command pulses
//   btn_reset, btn_test                one-cycle hold-complete pulses
//   count_reset, count_test            whole seconds held, saturating at 7
module tamagotchi_btn_frontend
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000000,
  parameter int HOLD_SECS       = 5,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               raw_salud,
  input  logic               raw_energia,
  input  logic               raw_hambre,
  input  logic               raw_diversion,
  input  logic               raw_reset,
  input  logic               raw_test,
  output logic               btn_salud,
  output logic               btn_energia,
  output logic               btn_hambre,
  output logic               btn_diversion,
  output logic               btn_reset,
  output logic               btn_test,
  output logic [COUNT_W-1:0] count_reset,
  output logic [COUNT_W-1:0] count_test
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [COUNT_W-1:0] HOLD_PRE  = COUNT_W'(HOLD_SECS - 1);
  localparam int HOLD_RST = 0;
  localparam int HOLD_TST = 1;

  if (HOLD_SECS < 1 || HOLD_SECS > 7 || DEBOUNCE_CYCLES < 1 ||
      TICK_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("tamagotchi_btn_frontend: parameter out of range");
  end

  logic [NUM_CARE-1:0] care_level, care_rise, care_evt;
  logic [1:0]          hold_level, hold_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_salud (
    .clk(clk), .rst_n(rst_n), .raw(raw_salud),
    .level(care_level[CARE_SALUD]), .rise(care_rise[CARE_SALUD]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_energia (
    .clk(clk), .rst_n(rst_n), .raw(raw_energia),
    .level(care_level[CARE_ENERGIA]), .rise(care_rise[CARE_ENERGIA]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hambre (
    .clk(clk), .rst_n(rst_n), .raw(raw_hambre),
    .level(care_level[CARE_HAMBRE]), .rise(care_rise[CARE_HAMBRE]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_diversion (
    .clk(clk), .rst_n(rst_n), .raw(raw_diversion),
    .level(care_level[CARE_DIVERSION]), .rise(care_rise[CARE_DIVERSION]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .clk(clk), .rst_n(rst_n), .raw(raw_reset),
    .level(hold_level[HOLD_RST]), .rise(hold_rise[HOLD_RST]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_test (
    .clk(clk), .rst_n(rst_n), .raw(raw_test),
    .level(hold_level[HOLD_TST]), .rise(hold_rise[HOLD_TST]));

  // ---------------------------------------------------------------------
  // Hold timers (index 0 = reset button, 1 = test button)
  // ---------------------------------------------------------------------
  hold_state_t        hold_st_q [2];
  hold_state_t        hold_st_d [2];
  logic [TICK_W-1:0]  presc_q   [2];
  logic [TICK_W-1:0]  presc_d   [2];
  logic [COUNT_W-1:0] secs_q    [2];
  logic [COUNT_W-1:0] secs_d    [2];
  logic [1:0]         fire_q, fire_d;

  // The pulse is raised on the very wrap that takes the count to HOLD_SECS,
  // so btn_* and the matching count value appear on the same edge.
  always_comb begin
    fire_d = '0;
    for (int i = 0; i < 2; i++) begin
      hold_st_d[i] = hold_st_q[i];
      presc_d[i]   = presc_q[i];
      secs_d[i]    = secs_q[i];
      case (hold_st_q[i])
        HOLD_IDLE: begin
          if (hold_rise[i]) begin
            hold_st_d[i] = HOLD_HOLDING;
            presc_d[i]   = '0;
            secs_d[i]    = '0;
          end
        end
        HOLD_HOLDING, HOLD_FIRED: begin
          if (!hold_level[i]) begin
            hold_st_d[i] = HOLD_IDLE;
            presc_d[i]   = '0;
            secs_d[i]    = '0;
          end else if (presc_q[i] == TICK_LAST) begin
            presc_d[i] = '0;
            if (secs_q[i] != COUNT_MAX) begin
              secs_d[i] = secs_q[i] + COUNT_W'(1);
            end
            if (hold_st_q[i] == HOLD_HOLDING && secs_q[i] == HOLD_PRE) begin
              fire_d[i]    = 1'b1;
              hold_st_d[i] = HOLD_FIRED;
            end
          end else begin
            presc_d[i] = presc_q[i] + TICK_W'(1);
          end
        end
        default: begin
          hold_st_d[i] = HOLD_IDLE;
          presc_d[i]   = '0;
          secs_d[i]    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        hold_st_q[i] <= HOLD_IDLE;
        presc_q[i]   <= '0;
        secs_q[i]    <= '0;
      end
      fire_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        hold_st_q[i] <= hold_st_d[i];
        presc_q[i]   <= presc_d[i];
        secs_q[i]    <= secs_d[i];
      end
      fire_q <= fire_d;
    end
  end

  // ---------------------------------------------------------------------
  // Care-button events: press strobes, plus repeat strobes when enabled
  // ---------------------------------------------------------------------
`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (TICK_CYCLES > REPEAT_CYCLES) ? TICK_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] ARM_LAST = RPT_W'(TICK_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [NUM_CARE-1:0] armed_q, armed_d, rpt_strobe;
  logic [RPT_W-1:0]    rpt_cnt_q [NUM_CARE];
  logic [RPT_W-1:0]    rpt_cnt_d [NUM_CARE];

  // Each button first waits one TICK period while held ("arming"), then the
  // same counter is reused to space the repeat strobes REPEAT_CYCLES apart.
  always_comb begin
    armed_d    = armed_q;
    rpt_strobe = '0;
    for (int i = 0; i < NUM_CARE; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (!care_level[i] || care_rise[i]) begin
        armed_d[i]   = 1'b0;
        rpt_cnt_d[i] = '0;
      end else if (!armed_q[i]) begin
        if (rpt_cnt_q[i] == ARM_LAST) begin
          armed_d[i]   = 1'b1;
          rpt_cnt_d[i] = '0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
        end
      end else if (rpt_cnt_q[i] == RPT_LAST) begin
        rpt_cnt_d[i]  = '0;
        rpt_strobe[i] = 1'b1;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= '0;
      for (int i = 0; i < NUM_CARE; i++) begin
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      armed_q <= armed_d;
      for (int i = 0; i < NUM_CARE; i++) begin
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign care_evt = care_rise | rpt_strobe;
`else
  // Without auto-repeat the debounced care levels have no consumer.
  logic unused_care_level;
  assign unused_care_level = ^care_level;
  assign care_evt = care_rise;
`endif

  // ---------------------------------------------------------------------
  // Priority arbitration; losers of a same-cycle tie are dropped
  // ---------------------------------------------------------------------
  logic [NUM_CARE-1:0] care_pulse_q, care_pulse_d;

  always_comb begin
    care_pulse_d = '0;
    if (!(hold_level[HOLD_RST] || hold_level[HOLD_TST])) begin
      if (care_evt[CARE_SALUD]) begin
        care_pulse_d[CARE_SALUD] = 1'b1;
      end else if (care_evt[CARE_ENERGIA]) begin
        care_pulse_d[CARE_ENERGIA] = 1'b1;
      end else if (care_evt[CARE_HAMBRE]) begin
        care_pulse_d[CARE_HAMBRE] = 1'b1;
      end else if (care_evt[CARE_DIVERSION]) begin
        care_pulse_d[CARE_DIVERSION] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      care_pulse_q <= '0;
    end else begin
      care_pulse_q <= care_pulse_d;
    end
  end

  assign btn_salud     = care_pulse_q[CARE_SALUD];
  assign btn_energia   = care_pulse_q[CARE_ENERGIA];
  assign btn_hambre    = care_pulse_q[CARE_HAMBRE];
  assign btn_diversion = care_pulse_q[CARE_DIVERSION];
  assign btn_reset     = fire_q[HOLD_RST];
  assign btn_test      = fire_q[HOLD_TST];
  assign count_reset   = secs_q[HOLD_RST];
  assign count_test    = secs_q[HOLD_TST];

endmodule
